collision_scanner: RTL and testbench
====================================

COLLISION_SCANNER -- requirements
Module: collision_scanner

Interface
REQ-001 Parameter N_OBJ, default 8, number of target objects scanned per request (2..64).
REQ-002 Parameter COORD_W, default 10, width of every coordinate (x, y).
REQ-003 Parameter SIZE_W, default 6, width of every width/height field.
REQ-004 Parameter IDX_W, default 3, width of the hit index; SHALL satisfy 2**IDX_W >= N_OBJ.
REQ-005 clk  in  1  system clock; all logic on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 clk_collision  in  1  one-cycle scan-request strobe (tick enable, not a clock).
REQ-008 obj_x  in  N_OBJ*COORD_W  flattened upper-left x; object i at bits [i*COORD_W +: COORD_W].
REQ-009 obj_y  in  N_OBJ*COORD_W  flattened upper-left y, same packing.
REQ-010 obj_width / obj_height  in  SIZE_W each  size shared by all objects.
REQ-011 obj_alive  in  N_OBJ  bit i = object i eligible for hit.
REQ-012 proj_x / proj_y  in  COORD_W each  projectile upper-left corner.
REQ-013 proj_width / proj_height  in  SIZE_W each  projectile size.
REQ-014 proj_valid  in  1  projectile in flight.
REQ-015 collision  out  1  one-cycle pulse: hit found.
REQ-016 hit_index  out  IDX_W  index of hit object; held until next hit.
REQ-017 kill_mask  out  N_OBJ  one-hot of hit object, valid only in collision cycle, else 0.
REQ-018 busy  out  1  high while a scan is in progress.
REQ-019 done  out  1  one-cycle pulse at end of every scan (hit or miss).

Function
REQ-020 FSM states IDLE, SCAN, REPORT; reset state IDLE.
REQ-021 IDLE: clk_collision=1 and proj_valid=1 -> latch proj_x/y/width/height and obj_alive into snapshot registers, clear scan index to 0, go SCAN; otherwise stay IDLE.
REQ-022 clk_collision with proj_valid=0 in IDLE SHALL be ignored (no done pulse).
REQ-023 clk_collision while in SCAN or REPORT SHALL be ignored; no queuing.
REQ-024 SCAN: one object per cycle, index i = 0,1,..,N_OBJ-1; obj_x/obj_y sampled live for the current index, width/height sampled live.
REQ-025 Hit test for object i: alive_snap[i]=1, obj_width!=0, obj_height!=0, proj size !=0, and obj_x < px+pw and px < obj_x+ow and obj_y < py+ph and py < obj_y+oh, all sums computed at COORD_W+1 bits (no wrap).
REQ-026 Edges touching without overlap (obj_x+ow == px) SHALL NOT be a hit.
REQ-027 First hit (lowest index) SHALL end the scan: register index into hit_index, go REPORT; higher indices not tested.
REQ-028 No hit after index N_OBJ-1 -> go REPORT with no-hit flag.
REQ-029 REPORT (one cycle): collision=1 and kill_mask=1<<hit_index if hit; done=1 always; then IDLE.
REQ-030 Latency: tick at cycle T -> done at T+1+k+1 where k = index of hit (0-based), or k = N_OBJ-1 on miss; worst case N_OBJ+1 cycles after tick.
REQ-031 busy=1 in SCAN and REPORT, 0 in IDLE.
REQ-032 Next tick accepted in the cycle after REPORT (back-to-back allowed).
REQ-033 Changes of proj_* or obj_alive during a scan SHALL NOT affect the scan in progress.

Reset
REQ-034 rst=1 at posedge -> state IDLE, scan index 0, collision=0, done=0, busy=0, kill_mask=0, hit_index=0, snapshots 0.
REQ-035 rst SHALL override clk_collision in the same cycle and abort any scan without producing collision or done.

Verification (N_OBJ=4, COORD_W=10, SIZE_W=6)
REQ-036 Objects at x=10,40,70,100 y=20, size 16x8, all alive; projectile (45,24) 2x4, tick -> collision and done 3 cycles after tick, hit_index=1, kill_mask=4'b0010.
REQ-037 Same but obj_alive=4'b1101 -> scan completes, done 5 cycles after tick, collision never asserted, hit_index keeps previous value.
REQ-038 Projectile (26,24) 2x4 (touches object 0 right edge at x=26) -> no hit; projectile (25,24) -> hit_index=0, done 2 cycles after tick.
REQ-039 Objects 1 and 2 overlapping projectile -> hit_index=1 only; second tick issued while busy -> ignored, exactly one done pulse.
REQ-040 rst asserted in 2nd SCAN cycle -> busy=0, no collision/done pulse; next tick after rst release scans normally from index 0.
REQ-041 obj_x=1020, width 16, proj_x=2 -> no hit (no coordinate wrap); tick with proj_valid=0 -> busy stays 0, no done.

Source files
------------

// File: rtl/collision_scanner.sv
// Sequential collision scanner: tests one target object per cycle against a
// latched projectile box and reports the lowest-index overlapping live object.
module collision_scanner #(
  parameter int N_OBJ   = 8,
  parameter int COORD_W = 10,
  parameter int SIZE_W  = 6,
  parameter int IDX_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_collision,
  input  logic [N_OBJ*COORD_W-1:0]   obj_x,
  input  logic [N_OBJ*COORD_W-1:0]   obj_y,
  input  logic [SIZE_W-1:0]          obj_width,
  input  logic [SIZE_W-1:0]          obj_height,
  input  logic [N_OBJ-1:0]           obj_alive,
  input  logic [COORD_W-1:0]         proj_x,
  input  logic [COORD_W-1:0]         proj_y,
  input  logic [SIZE_W-1:0]          proj_width,
  input  logic [SIZE_W-1:0]          proj_height,
  input  logic                       proj_valid,
  output logic                       collision,
  output logic [IDX_W-1:0]           hit_index,
  output logic [N_OBJ-1:0]           kill_mask,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t               state, state_next;
  logic [IDX_W-1:0]     idx;
  logic [COORD_W-1:0]   px_snap, py_snap;
  logic [SIZE_W-1:0]    pw_snap, ph_snap;
  logic [N_OBJ-1:0]     alive_snap;
  logic                 hit_flag;

  logic [COORD_W-1:0]   cur_x, cur_y;
  logic                 hit_now;
  logic                 last_idx;
  logic                 start;

  // Overlap ends are formed one bit wider so boxes near the coordinate limit never wrap.
  always_comb begin
    cur_x    = obj_x[int'(idx)*COORD_W +: COORD_W];
    cur_y    = obj_y[int'(idx)*COORD_W +: COORD_W];
    hit_now  = alive_snap[idx]
             && (obj_width != '0) && (obj_height != '0)
             && (pw_snap != '0) && (ph_snap != '0)
             && ((COORD_W+1)'(cur_x) < (COORD_W+1)'(px_snap) + (COORD_W+1)'(pw_snap))
             && ((COORD_W+1)'(px_snap) < (COORD_W+1)'(cur_x) + (COORD_W+1)'(obj_width))
             && ((COORD_W+1)'(cur_y) < (COORD_W+1)'(py_snap) + (COORD_W+1)'(ph_snap))
             && ((COORD_W+1)'(py_snap) < (COORD_W+1)'(cur_y) + (COORD_W+1)'(obj_height));
    last_idx = (idx == IDX_W'(N_OBJ-1));
    start    = clk_collision && proj_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    collision  = 1'b0;
    kill_mask  = '0;
    case (state)
      IDLE: begin
        if (start) state_next = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (hit_now || last_idx) state_next = REPORT;
      end
      REPORT: begin
        busy       = 1'b1;
        done       = 1'b1;
        collision  = hit_flag;
        if (hit_flag) kill_mask = N_OBJ'(1) << hit_index;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      px_snap    <= '0;
      py_snap    <= '0;
      pw_snap    <= '0;
      ph_snap    <= '0;
      alive_snap <= '0;
      hit_flag   <= 1'b0;
      hit_index  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            px_snap    <= proj_x;
            py_snap    <= proj_y;
            pw_snap    <= proj_width;
            ph_snap    <= proj_height;
            alive_snap <= obj_alive;
            idx        <= '0;
            hit_flag   <= 1'b0;
          end
        end
        SCAN: begin
          if (hit_now) begin
            hit_index <= idx;
            hit_flag  <= 1'b1;
          end else if (!last_idx) begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scanner.sv
// Scoreboard bench for collision_scanner: a box-overlap reference model predicts
// each accepted scan; a monitor checks every cycle's outputs against the queue.
module tb_collision_scanner;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int SW = 6;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clk_collision = 1'b0;
  logic [N*CW-1:0] obj_x = '0;
  logic [N*CW-1:0] obj_y = '0;
  logic [SW-1:0]   obj_width = '0;
  logic [SW-1:0]   obj_height = '0;
  logic [N-1:0]    obj_alive = '0;
  logic [CW-1:0]   proj_x = '0;
  logic [CW-1:0]   proj_y = '0;
  logic [SW-1:0]   proj_width = '0;
  logic [SW-1:0]   proj_height = '0;
  logic            proj_valid = 1'b0;
  logic            collision;
  logic [IW-1:0]   hit_index;
  logic [N-1:0]    kill_mask;
  logic            busy;
  logic            done;

  collision_scanner #(.N_OBJ(N), .COORD_W(CW), .SIZE_W(SW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .clk_collision(clk_collision),
    .obj_x(obj_x), .obj_y(obj_y), .obj_width(obj_width), .obj_height(obj_height),
    .obj_alive(obj_alive), .proj_x(proj_x), .proj_y(proj_y),
    .proj_width(proj_width), .proj_height(proj_height), .proj_valid(proj_valid),
    .collision(collision), .hit_index(hit_index), .kill_mask(kill_mask),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int tick_cyc;
    int done_cyc;
    bit hit;
    int idx;
    int hidx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   free_cyc = 0;
  int   last_hidx = 0;
  bit   mon_en = 1'b0;

  int       ox[N];
  int       oy[N];
  int       ow, oh, px, py, pw, ph;
  bit [N-1:0] alive_v;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain axis-aligned box overlap on unbounded integers; first live hit wins.
  function automatic int ref_hit();
    for (int i = 0; i < N; i++) begin
      if (alive_v[i] && ow != 0 && oh != 0 && pw != 0 && ph != 0 &&
          ox[i] < px + pw && px < ox[i] + ow &&
          oy[i] < py + ph && py < oy[i] + oh)
        return i;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      obj_x[i*CW +: CW] = CW'(ox[i]);
      obj_y[i*CW +: CW] = CW'(oy[i]);
    end
    obj_width   = SW'(ow);
    obj_height  = SW'(oh);
    obj_alive   = alive_v;
    proj_x      = CW'(px);
    proj_y      = CW'(py);
    proj_width  = SW'(pw);
    proj_height = SW'(ph);
  endtask

  task automatic step(input bit tk, input bit pv, input bit scr);
    exp_t e;
    int   k;
    @(negedge clk);
    if (scr) begin
      px = $urandom_range(0, 130);
      py = $urandom_range(0, 50);
      pw = $urandom_range(0, 12);
      ph = $urandom_range(0, 12);
      alive_v = N'($urandom);
    end
    drive();
    clk_collision = tk;
    proj_valid    = pv;
    if (tk && pv && cyc >= free_cyc) begin
      k          = ref_hit();
      e.tick_cyc = cyc;
      e.hit      = (k >= 0);
      e.idx      = e.hit ? k : 0;
      e.done_cyc = cyc + (e.hit ? k : N - 1) + 2;
      if (e.hit) last_hidx = k;
      e.hidx     = last_hidx;
      sb.push_back(e);
      free_cyc   = e.done_cyc + 1;
    end
  endtask

  task automatic wait_idle();
    while (cyc < free_cyc) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic rst_seq(input int n);
    @(negedge clk);
    rst = 1'b1;
    clk_collision = 1'b0;
    repeat (n) @(posedge clk);
    sb.delete();
    free_cyc  = 0;
    last_hidx = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_hit_index", int'(hit_index), 0);
    chk("rst_busy", int'(busy), 0);
  endtask

  task automatic base_objs();
    ox[0] = 10; ox[1] = 40; ox[2] = 70; ox[3] = 100;
    for (int i = 0; i < N; i++) oy[i] = 20;
    ow = 16; oh = 8; alive_v = '1;
    px = 45; py = 24; pw = 2; ph = 4;
  endtask

  // Monitor: every cycle, outputs must match the head of the scoreboard.
  initial begin
    exp_t e;
    int   exp_busy;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        exp_busy = (sb.size() > 0 && cyc > sb[0].tick_cyc) ? 1 : 0;
        chk("busy", int'(busy), exp_busy);
        if (sb.size() > 0 && cyc == sb[0].done_cyc) begin
          e = sb.pop_front();
          chk("done", int'(done), 1);
          chk("collision", int'(collision), int'(e.hit));
          chk("kill_mask", int'(kill_mask), e.hit ? (1 << e.idx) : 0);
          chk("hit_index", int'(hit_index), e.hidx);
        end else begin
          chk("quiet_outputs", int'({done, collision, kill_mask}), 0);
        end
      end
    end
  end

  initial begin
    base_objs();
    drive();
    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    #1;
    chk("reset_done", int'(done), 0);
    chk("reset_collision", int'(collision), 0);
    chk("reset_kill_mask", int'(kill_mask), 0);
    chk("reset_hit_index", int'(hit_index), 0);
    @(negedge clk);
    rst = 1'b0;

    // Hit on object 1
    base_objs();
    step(1'b1, 1'b1, 1'b0);
    wait_idle();

    // Object 1 dead: full miss, hit_index held
    alive_v = 4'b1101;
    step(1'b1, 1'b1, 1'b0);
    wait_idle();

    // Touching right edge of object 0 is not a hit; one pixel left is
    base_objs();
    px = 26;
    step(1'b1, 1'b1, 1'b0);
    wait_idle();
    px = 25;
    step(1'b1, 1'b1, 1'b0);
    wait_idle();

    // Straddles objects 1 and 2; a second tick while busy must be dropped
    base_objs();
    px = 50; pw = 30;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    wait_idle();

    // Reset in the second scan cycle aborts, then a fresh scan works
    base_objs();
    px = 300;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst_seq(1);
    base_objs();
    step(1'b1, 1'b1, 1'b0);
    wait_idle();

    // Object near coordinate limit must not wrap onto a low projectile
    base_objs();
    ox[0] = 1020; ox[1] = 500; ox[2] = 500; ox[3] = 500;
    px = 2;
    step(1'b1, 1'b1, 1'b0);
    wait_idle();
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);

    for (int it = 0; it < 150; it++) begin
      wait_idle();
      for (int i = 0; i < N; i++) begin
        ox[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 120);
        oy[i] = $urandom_range(0, 40);
      end
      ow = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
      oh = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
      alive_v = N'($urandom);
      px = $urandom_range(0, 130);
      py = $urandom_range(0, 50);
      pw = $urandom_range(0, 12);
      ph = $urandom_range(0, 12);
      step(1'b1, $urandom_range(0, 7) != 0, 1'b0);
      repeat ($urandom_range(1, 6)) step($urandom_range(0, 3) == 0, 1'b1, 1'b1);
    end

    wait_idle();
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
